// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set controller: turns GMII TX_EN/TX_ER/TXD into
// the per-cycle code group for the 8b/10b encoder, keeping idles even-aligned.
module pcs_tx_ordered_set #(
   parameter int CNT_W = 16
) (
   input  logic             GTX_CLK,
   input  logic             mr_main_reset,
   input  logic             TX_EN,
   input  logic             TX_ER,
   input  logic [7:0]       TXD,
   output logic [7:0]       tx_o_set,
   output logic             tx_o_set_k,
   output logic             tx_even,
   output logic             transmitting,
   output logic [CNT_W-1:0] tx_frame_cnt
);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] D16_2 = 8'h50;
   localparam logic [7:0] K_S   = 8'hFB;
   localparam logic [7:0] K_T   = 8'hFD;
   localparam logic [7:0] K_R   = 8'hF7;
   localparam logic [7:0] K_V   = 8'hFE;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE_K,
      IDLE_D,
      SOP,
      DATA,
      EOP,
      EPD2,
      EPD3
   } state_t;

   state_t state;

   // The state names the code group currently on tx_o_set, so every branch
   // loads the outputs belonging to the state it moves into.
   always_ff @(posedge GTX_CLK) begin
      if (mr_main_reset) begin
         state        <= IDLE_K;
         tx_o_set     <= K28_5;
         tx_o_set_k   <= 1'b1;
         tx_even      <= 1'b1;
         transmitting <= 1'b0;
         tx_frame_cnt <= '0;
      end else begin
         tx_even <= ~tx_even;
         case (state)
            IDLE_K: begin
               state        <= IDLE_D;
               tx_o_set     <= D16_2;
               tx_o_set_k   <= 1'b0;
               transmitting <= 1'b0;
            end
            // A frame may only begin from the odd idle slot so /S/ lands even.
            IDLE_D: begin
               if (TX_EN) begin
                  state        <= SOP;
                  tx_o_set     <= K_S;
                  tx_o_set_k   <= 1'b1;
                  transmitting <= 1'b1;
               end else begin
                  state        <= IDLE_K;
                  tx_o_set     <= K28_5;
                  tx_o_set_k   <= 1'b1;
                  transmitting <= 1'b0;
               end
            end
            SOP, DATA: begin
               if (TX_EN) begin
                  state        <= DATA;
                  tx_o_set     <= TX_ER ? K_V : TXD;
                  tx_o_set_k   <= TX_ER;
                  transmitting <= 1'b1;
               end else begin
                  state        <= EOP;
                  tx_o_set     <= K_T;
                  tx_o_set_k   <= 1'b1;
                  transmitting <= 1'b1;
                  tx_frame_cnt <= tx_frame_cnt + CNT_ONE;
               end
            end
            EOP: begin
               state        <= EPD2;
               tx_o_set     <= K_R;
               tx_o_set_k   <= 1'b1;
               transmitting <= 1'b0;
            end
            // A second /R/ pads an even-slot /R/ so the next /K28.5/ is even.
            EPD2: begin
               tx_o_set_k   <= 1'b1;
               transmitting <= 1'b0;
               if (tx_even) begin
                  state    <= EPD3;
                  tx_o_set <= K_R;
               end else begin
                  state    <= IDLE_K;
                  tx_o_set <= K28_5;
               end
            end
            EPD3: begin
               state        <= IDLE_K;
               tx_o_set     <= K28_5;
               tx_o_set_k   <= 1'b1;
               transmitting <= 1'b0;
            end
            default: begin
               state        <= IDLE_K;
               tx_o_set     <= K28_5;
               tx_o_set_k   <= 1'b1;
               transmitting <= 1'b0;
            end
         endcase
      end
   end

endmodule
